rf_wb_buffer: RTL and testbench
===============================

# rf_wb_buffer

Register-file write-back buffer for the SISC datapath: the write-side counterpart to the read-address selection that feeds the register file's read ports. Accepts completed results tagged with the instruction word and a destination-field select, decodes the destination register from the selected IR field, and queues up to two pending writes. Drains them one per granted cycle into the register file write port. Provides forwarding lookups so read ports can see values still queued.

## Interface
- DW, 32, data width of results and register contents
- DEPTH, 2, pending-write entries (fixed at 2; not a free parameter for this revision)
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  result available
- in_ready  out  1  buffer can accept this cycle
- in_ir  in  32  instruction word of the producing instruction
- in_wb_sel  in  2  destination field: 0 = ir[23:20], 1 = ir[15:12], 2 = ir[19:16], 3 = no write
- in_data  in  DW  result value
- flush  in  1  discard all pending entries
- rf_grant  in  1  register file write port available this cycle
- rf_we  out  1  write strobe to register file
- rf_waddr  out  4  write address
- rf_wdata  out  DW  write data
- rd_addr_a, rd_addr_b  in  4 each  read-port addresses to check
- fwd_hit_a, fwd_hit_b  out  1 each  a pending entry targets that address
- fwd_data_a, fwd_data_b  out  DW each  youngest matching pending data
- count  out  2  number of occupied entries (0..2)

## Operation
- Storage: 2-entry FIFO of {addr[3:0], data[DW-1:0]}; head pointer, tail pointer, count register.
- Accept: a transfer occurs on a rising edge where in_valid && in_ready. in_ready = !rst && count < 2, combinational.
- Address decode at accept: per in_wb_sel; decoded address 0 or in_wb_sel == 3 -> transfer completes (handshake consumed) but nothing is enqueued. R0 is never written.
- Drain: rf_we = (count != 0) && rf_grant && !flush; rf_waddr/rf_wdata = head entry (zero when count == 0). The head pops on the same edge rf_we is high.
- Push and pop on the same edge: count unchanged; ordering preserved (FIFO, oldest written first).
- Flush: synchronous; on the edge where flush is high, count, head and tail -> 0. Flush has priority over push and pop; no write is issued in a flush cycle; a concurrent in_valid is consumed if in_ready and dropped.
- Forwarding (combinational): fwd_hit_x = rd_addr_x != 0 && any occupied entry has addr == rd_addr_x. fwd_data_x = data of the youngest such entry (tail-most), else 0. Only queued entries are searched; the incoming in_data is not bypassed.
- Widths: addresses 4 bits, pointers 1 bit, wrapping modulo 2; count saturates by construction (never pushes when full).

## Timing
- Reset (rst high on an edge): count = 0, pointers = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit_* = 0, fwd_data_* = 0. in_ready = 0 while rst is high, 1 on the first cycle after.
- Reset mid-operation discards all pending entries; no write is issued in the reset cycle.
- Latency: an entry accepted at edge N can appear on rf_we in the cycle after edge N, i.e. it is written at edge N+1 if rf_grant is high. With rf_grant low, entries hold indefinitely.
- Full: count == 2 -> in_ready = 0 in the same cycle. A pop at edge N reopens in_ready in the cycle after edge N, not in the same cycle.
- Forward outputs reflect state after the most recent edge; an entry becomes visible one cycle after acceptance and disappears on the edge it is written.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 -> in_ready = 0, count = 0, rf_we = 0, no entries enqueued; after release in_ready = 1.
- Field decode: ir = 32'h0053_2000 with wb_sel = 0, 1, 2 and data 11, 22, 33, rf_grant = 1 -> writes R5 = 11, R2 = 22, R3 = 33 on successive edges. wb_sel = 3 or decoded R0 -> handshake completes, no rf_we.
- Backpressure: rf_grant = 0, push R1 = A, then R1 = B -> count = 2, in_ready = 0, fwd_hit_a = 1 for rd_addr_a = 1 with fwd_data_a = B. Raise rf_grant -> R1 = A then R1 = B are written in order, and count returns to 0.
- Simultaneous push/pop: count = 1 (R4 = 7), rf_grant = 1, push R6 = 9 -> R4 = 7 is written, count stays 1, next cycle R6 = 9 is written.
- Flush: count = 2, assert flush with in_valid = 1 and rf_grant = 1 -> no rf_we that cycle, count = 0 next cycle, fwd_hit_* = 0.
- Forward miss/R0: rd_addr_a = 0 with a pending entry for R0 impossible; rd_addr_b unmatched -> fwd_hit_b = 0, fwd_data_b = 0.

Source files
------------

// File: rtl/rf_wb_buffer.sv
// Register-file write-back buffer: decodes the destination from the IR, queues up to two
// pending writes, drains one per granted cycle, and forwards queued data to the read ports.
module rf_wb_buffer #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_ir,
  input  logic [1:0]    in_wb_sel,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  input  logic          rf_grant,
  output logic          rf_we,
  output logic [3:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [3:0]    rd_addr_a,
  input  logic [3:0]    rd_addr_b,
  output logic          fwd_hit_a,
  output logic          fwd_hit_b,
  output logic [DW-1:0] fwd_data_a,
  output logic [DW-1:0] fwd_data_b,
  output logic [1:0]    count
);

  logic [3:0]    r_addr [2];
  logic [DW-1:0] r_data [2];
  logic          r_head;
  logic          r_tail;
  logic [1:0]    r_count;

  logic [3:0]    w_dec_addr;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_ir;

  assign w_unused_ir = ^{in_ir[31:24], in_ir[11:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_dec_addr = '0;
    case (in_wb_sel)
      2'd0:    w_dec_addr = in_ir[23:20];
      2'd1:    w_dec_addr = in_ir[15:12];
      2'd2:    w_dec_addr = in_ir[19:16];
      default: w_dec_addr = '0;
    endcase
  end

  assign in_ready = !rst && (r_count < 2'(DEPTH));
  // R0 and "no write" selections still consume the handshake but never enter the queue.
  assign w_push   = in_valid && in_ready && (w_dec_addr != 4'd0);
  assign rf_we    = (r_count != 2'd0) && rf_grant && !flush && !rst;
  assign w_pop    = rf_we;
  assign rf_waddr = (r_count != 2'd0) ? r_addr[r_head] : 4'd0;
  assign rf_wdata = (r_count != 2'd0) ? r_data[r_head] : '0;
  assign count    = r_count;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; r_count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= w_dec_addr;
      r_data[r_tail] <= in_data;
    end
  end

  // The entry just behind the tail is always the youngest; the other is only live when full.
  function automatic logic [DW:0] lookup(input logic [3:0] a);
    logic y;
    y = ~r_tail;
    if (a != 4'd0 && r_count != 2'd0 && r_addr[y] == a)
      return {1'b1, r_data[y]};
    if (a != 4'd0 && r_count == 2'd2 && r_addr[~y] == a)
      return {1'b1, r_data[~y]};
    return '0;
  endfunction

  always_comb begin
    {fwd_hit_a, fwd_data_a} = lookup(rd_addr_a);
    {fwd_hit_b, fwd_data_b} = lookup(rd_addr_b);
  end

endmodule

// File: tb/tb_rf_wb_buffer.sv
// Testbench for rf_wb_buffer: directed scenarios plus randomized traffic checked against
// a queue-based model of the pending writes.
module tb_rf_wb_buffer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, rf_grant, rf_we;
  logic [31:0]   in_ir;
  logic [1:0]    in_wb_sel, count;
  logic [DW-1:0] in_data, rf_wdata, fwd_data_a, fwd_data_b;
  logic [3:0]    rf_waddr, rd_addr_a, rd_addr_b;
  logic          fwd_hit_a, fwd_hit_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [3:0] addr; logic [DW-1:0] data; } ent_t;
  ent_t q[$];

  rf_wb_buffer #(.DW(DW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .in_wb_sel(in_wb_sel), .in_data(in_data), .flush(flush), .rf_grant(rf_grant),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] decode(input logic [31:0] ir, input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'((ir >> 20) & 32'hF);
      2'd1:    return 4'((ir >> 12) & 32'hF);
      2'd2:    return 4'((ir >> 16) & 32'hF);
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [DW:0] fwd(input logic [3:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (a != 4'd0 && q[i].addr == a) return {1'b1, q[i].data};
    return '0;
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit rdy, we;
    logic [3:0] d;
    rdy = !rst && q.size() < 2;
    we  = q.size() != 0 && rf_grant && !flush && !rst;
    d   = decode(in_ir, in_wb_sel);
    if (rst || flush) q.delete();
    else begin
      if (we) void'(q.pop_front());
      if (in_valid && rdy && d != 4'd0) q.push_back('{addr: d, data: in_data});
    end
  endtask

  task automatic cyc();
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [1:0] sel,
                       input logic [DW-1:0] d, input logic g, input logic f);
    in_valid = v; in_ir = ir; in_wb_sel = sel; in_data = d; rf_grant = g; flush = f;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_ir = 32'h0050_0000; in_wb_sel = 2'd0; in_data = 32'd99;
    rf_grant = 1'b1; flush = 1'b0; rd_addr_a = 4'd5; rd_addr_b = 4'd0;
    repeat (2) begin
      cyc(); #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
      n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
      n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", rf_we); end
      n_cmp++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== '0) begin n_bad++; $display("FAIL rst_fwd: got %b/%0h want 0/0", fwd_hit_a, fwd_data_a); end
    end
    rst = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    n_cmp++; if (rf_waddr !== 4'd0 || rf_wdata !== '0) begin n_bad++; $display("FAIL rst_wport: got %0d/%0h want 0/0", rf_waddr, rf_wdata); end
    cyc();
  endtask

  task automatic test_decode();
    logic [31:0] ir;
    ir = 32'h0053_2000;
    drive(1, ir, 2'd0, 32'd11, 1, 0);
    n_cmp++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL dec_first: got we=%b rdy=%b want 0/1", rf_we, in_ready); end
    cyc(); drive(1, ir, 2'd1, 32'd22, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd5, 32'd11}) begin n_bad++; $display("FAIL dec_r5: got %b R%0d=%0d want 1 R5=11", rf_we, rf_waddr, rf_wdata); end
    cyc(); drive(1, ir, 2'd2, 32'd33, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd2, 32'd22}) begin n_bad++; $display("FAIL dec_r2: got %b R%0d=%0d want 1 R2=22", rf_we, rf_waddr, rf_wdata); end
    cyc(); drive(0, ir, 2'd0, 32'd0, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 32'd33}) begin n_bad++; $display("FAIL dec_r3: got %b R%0d=%0d want 1 R3=33", rf_we, rf_waddr, rf_wdata); end
    cyc(); drive(1, ir, 2'd3, 32'd44, 1, 0);
    n_cmp++; if (count !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL dec_sel3_pre: got cnt=%0d rdy=%b want 0/1", count, in_ready); end
    cyc(); drive(1, 32'h0, 2'd0, 32'd55, 1, 0);
    n_cmp++; if (count !== 2'd0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL dec_sel3: got cnt=%0d we=%b want 0/0", count, rf_we); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if (count !== 2'd0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL dec_r0: got cnt=%0d we=%b want 0/0", count, rf_we); end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b;
    a = $urandom; b = $urandom; rd_addr_a = 4'd1;
    drive(1, 32'h0010_0000, 2'd0, a, 0, 0);
    cyc(); drive(1, 32'h0010_0000, 2'd0, b, 0, 0);
    n_cmp++; if (count !== 2'd1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL bp_one: got cnt=%0d we=%b want 1/0", count, rf_we); end
    n_cmp++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== a) begin n_bad++; $display("FAIL bp_fwd_a: got %b/%0h want 1/%0h", fwd_hit_a, fwd_data_a, a); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 0, 0);
    n_cmp++; if (count !== 2'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got cnt=%0d rdy=%b want 2/0", count, in_ready); end
    n_cmp++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== b) begin n_bad++; $display("FAIL bp_fwd_young: got %b/%0h want 1/%0h", fwd_hit_a, fwd_data_a, b); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd1, a}) begin n_bad++; $display("FAIL bp_wr_a: got %b R%0d=%0h want 1 R1=%0h", rf_we, rf_waddr, rf_wdata, a); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_same: got %b want 0", in_ready); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd1, b}) begin n_bad++; $display("FAIL bp_wr_b: got %b R%0d=%0h want 1 R1=%0h", rf_we, rf_waddr, rf_wdata, b); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_reopen: got %b want 1", in_ready); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if (count !== 2'd0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got cnt=%0d we=%b want 0/0", count, rf_we); end
    cyc();
  endtask

  task automatic test_push_pop();
    drive(1, 32'h0040_0000, 2'd0, 32'd7, 0, 0);
    cyc(); drive(1, 32'h0060_0000, 2'd0, 32'd9, 1, 0);
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd4, 32'd7}) begin n_bad++; $display("FAIL pp_r4: got %b R%0d=%0d want 1 R4=7", rf_we, rf_waddr, rf_wdata); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if (count !== 2'd1) begin n_bad++; $display("FAIL pp_count: got %0d want 1", count); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd6, 32'd9}) begin n_bad++; $display("FAIL pp_r6: got %b R%0d=%0d want 1 R6=9", rf_we, rf_waddr, rf_wdata); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 0, 0);
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL pp_empty: got %0d want 0", count); end
    cyc();
  endtask

  task automatic test_flush();
    rd_addr_a = 4'd7; rd_addr_b = 4'd8;
    drive(1, 32'h0070_0000, 2'd0, 32'd1, 0, 0);
    cyc(); drive(1, 32'h0080_0000, 2'd0, 32'd2, 0, 0);
    cyc(); drive(1, 32'h0090_0000, 2'd0, 32'd3, 1, 1);
    n_cmp++; if (rf_we !== 1'b0 || count !== 2'd2) begin n_bad++; $display("FAIL fl_cycle: got we=%b cnt=%0d want 0/2", rf_we, count); end
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    n_cmp++; if (count !== 2'd0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL fl_after: got cnt=%0d we=%b want 0/0", count, rf_we); end
    n_cmp++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin n_bad++; $display("FAIL fl_fwd: got %b/%b want 0/0", fwd_hit_a, fwd_hit_b); end
    cyc();
  endtask

  task automatic test_fwd_miss();
    rd_addr_a = 4'd0; rd_addr_b = 4'd9;
    drive(1, 32'h0050_0000, 2'd0, 32'd77, 0, 0);
    cyc(); drive(0, 32'h0, 2'd0, 32'd0, 0, 0);
    n_cmp++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== '0) begin n_bad++; $display("FAIL fm_r0: got %b/%0h want 0/0", fwd_hit_a, fwd_data_a); end
    n_cmp++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== '0) begin n_bad++; $display("FAIL fm_miss: got %b/%0h want 0/0", fwd_hit_b, fwd_data_b); end
    rd_addr_b = 4'd5; #1;
    n_cmp++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 32'd77) begin n_bad++; $display("FAIL fm_hit: got %b/%0d want 1/77", fwd_hit_b, fwd_data_b); end
    drive(0, 32'h0, 2'd0, 32'd0, 1, 0);
    cyc();
  endtask

  task automatic test_random();
    logic [DW:0] ea, eb;
    logic [3:0] hw;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) < 2); rd_addr_a = 4'($urandom_range(0, 3)); rd_addr_b = 4'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 99) < 60), $urandom & 32'h0033_3000, 2'($urandom), $urandom,
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));
      ea = fwd(rd_addr_a); eb = fwd(rd_addr_b);
      hw = (q.size() != 0) ? q[0].addr : 4'd0;
      n_cmp++; if (in_ready !== (!rst && q.size() < 2)) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b", n, in_ready); end
      n_cmp++; if (count !== 2'(q.size())) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, q.size()); end
      n_cmp++; if (rf_we !== (q.size() != 0 && rf_grant && !flush && !rst)) begin n_bad++; $display("FAIL rnd_we@%0d: got %b", n, rf_we); end
      n_cmp++; if (rf_waddr !== hw || rf_wdata !== ((q.size() != 0) ? q[0].data : '0)) begin n_bad++; $display("FAIL rnd_head@%0d: got R%0d=%0h want R%0d", n, rf_waddr, rf_wdata, hw); end
      n_cmp++; if ({fwd_hit_a, fwd_data_a} !== ea) begin n_bad++; $display("FAIL rnd_fwd_a@%0d: got %b/%0h want %b/%0h", n, fwd_hit_a, fwd_data_a, ea[DW], ea[DW-1:0]); end
      n_cmp++; if ({fwd_hit_b, fwd_data_b} !== eb) begin n_bad++; $display("FAIL rnd_fwd_b@%0d: got %b/%0h want %b/%0h", n, fwd_hit_b, fwd_data_b, eb[DW], eb[DW-1:0]); end
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_fwd_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
